// File: rtl/sram_cfg_pkg.sv
// Shared SRAM width-configuration constants, the packer state encoding
// and lane helpers. Also used by the read-side output shifter.
package sram_cfg_pkg;

  localparam int MASK_W = 4;
  localparam logic [MASK_W-1:0] MASK_FULL = '1;

  localparam logic [1:0] CONF_32 = 2'b00;
  localparam logic [1:0] CONF_16 = 2'b01;
  localparam logic [1:0] CONF_8  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    FULL  = 2'b10
  } state_e;

  // The reserved encoding 2'b11 behaves exactly like 32-bit mode.
  function automatic logic [1:0] norm_conf(input logic [1:0] c);
    return (c == 2'b11) ? CONF_32 : c;
  endfunction

  // Overwrite the bytes of old_d selected by m with the bytes of new_d.
  function automatic logic [31:0] merge_lanes(input logic [31:0]       old_d,
                                              input logic [31:0]       new_d,
                                              input logic [MASK_W-1:0] m);
    logic [31:0] r;
    r = old_d;
    for (int i = 0; i < MASK_W; i++) begin
      if (m[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_steer_8_32.sv
// Places a right-aligned narrow write into its byte lanes of the 32-bit word
// and derives the word address and byte mask.
module lane_steer_8_32
  import sram_cfg_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        conf,
  output logic [31:0]       steer_data,
  output logic [MASK_W-1:0] steer_mask,
  output logic [ADDR_W-1:0] steer_addr
);

  // Little-endian lane steering; the word address is zero-extended.
  always_comb begin
    steer_data = '0;
    steer_mask = '0;
    steer_addr = '0;
    case (norm_conf(conf))
      CONF_16: begin
        steer_addr = {1'b0, in_addr[ADDR_W-1:1]};
        if (in_addr[0]) begin
          steer_data = {in_data[15:0], 16'h0000};
          steer_mask = 4'b1100;
        end else begin
          steer_data = {16'h0000, in_data[15:0]};
          steer_mask = 4'b0011;
        end
      end
      CONF_8: begin
        steer_addr = {2'b00, in_addr[ADDR_W-1:2]};
        steer_data = {24'h000000, in_data[7:0]} << {in_addr[1:0], 3'b000};
        steer_mask = 4'b0001 << in_addr[1:0];
      end
      default: begin
        steer_addr = in_addr;
        steer_data = in_data;
        steer_mask = MASK_FULL;
      end
    endcase
  end

endmodule

// File: rtl/input_packer_8_32.sv
// Coalesces narrow SRAM writes into 32-bit macro writes with byte enables.
//
//  state | meaning
//  IDLE  | nothing held, any request is accepted
//  ACCUM | partial word held, only same-word same-width requests accepted
//  FULL  | word presented on out_*, waiting for out_ready
//
// in_ready in FULL follows out_ready combinationally so a handoff and a new
// load can share one cycle.
module input_packer_8_32
  import sram_cfg_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        conf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [MASK_W-1:0] out_wmask
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state, state_n;
  logic [31:0]       hold_data, hold_data_n;
  logic [MASK_W-1:0] hold_mask, hold_mask_n;
  logic [ADDR_W-1:0] hold_addr, hold_addr_n;
  logic [1:0]        hold_conf, hold_conf_n;
  logic [CNT_W-1:0]  tcount, tcount_n;

  logic [31:0]       s_data;
  logic [MASK_W-1:0] s_mask;
  logic [ADDR_W-1:0] s_addr;
  logic [1:0]        conf_n;
  logic              match;
  logic [31:0]       merged_data;
  logic [MASK_W-1:0] merged_mask;
  logic              timeout_hit;
  logic              out_load;

  lane_steer_8_32 #(.ADDR_W(ADDR_W)) u_steer (
    .in_data    (in_data),
    .in_addr    (in_addr),
    .conf       (conf),
    .steer_data (s_data),
    .steer_mask (s_mask),
    .steer_addr (s_addr)
  );

  assign conf_n      = norm_conf(conf);
  assign match       = (s_addr == hold_addr) && (conf_n == hold_conf);
  assign merged_data = merge_lanes(hold_data, s_data, s_mask);
  assign merged_mask = hold_mask | s_mask;
  assign timeout_hit = (TIMEOUT > 0) && (tcount == CNT_W'(TIMEOUT - 1));

  // Next-state, hold-register and timeout-counter logic.
  always_comb begin
    state_n     = state;
    hold_data_n = hold_data;
    hold_mask_n = hold_mask;
    hold_addr_n = hold_addr;
    hold_conf_n = hold_conf;
    tcount_n    = tcount;
    in_ready    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_data_n = s_data;
          hold_mask_n = s_mask;
          hold_addr_n = s_addr;
          hold_conf_n = conf_n;
          tcount_n    = '0;
          state_n     = (s_mask == MASK_FULL) ? FULL : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = match;
        if (in_valid && match) begin
          hold_data_n = merged_data;
          hold_mask_n = merged_mask;
          tcount_n    = '0;
          if (merged_mask == MASK_FULL || flush) state_n = FULL;
        end else if (in_valid || flush) begin
          state_n = FULL;
        end else begin
          tcount_n = tcount + 1'b1;
          if (timeout_hit) state_n = FULL;
        end
      end
      FULL: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            hold_data_n = s_data;
            hold_mask_n = s_mask;
            hold_addr_n = s_addr;
            hold_conf_n = conf_n;
            tcount_n    = '0;
            state_n     = (s_mask == MASK_FULL) ? FULL : ACCUM;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != ACCUM) tcount_n = '0;
  end

  // Output word is captured only when a new word enters FULL.
  assign out_load = (state_n == FULL) && ((state != FULL) || out_ready);

  // State, hold registers and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_mask <= '0;
      hold_addr <= '0;
      hold_conf <= CONF_32;
      tcount    <= '0;
    end else begin
      state     <= state_n;
      hold_data <= hold_data_n;
      hold_mask <= hold_mask_n;
      hold_addr <= hold_addr_n;
      hold_conf <= hold_conf_n;
      tcount    <= tcount_n;
    end
  end

  // Registered macro-write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wmask <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= (state_n == FULL);
      if (out_load) begin
        out_data  <= hold_data_n;
        out_wmask <= hold_mask_n;
        out_addr  <= hold_addr_n;
      end
    end
  end

endmodule

// File: tb/tb_input_packer_8_32.sv
// Directed bench for input_packer_8_32: single-write vector table plus
// hand-written multi-cycle sequences.
module tb_input_packer_8_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [9:0]  in_addr;
  logic [1:0]  conf;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_wmask;

  int checks = 0;
  int failures = 0;

  input_packer_8_32 #(.ADDR_W(10), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .conf      (conf),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_wmask (out_wmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  conf;
    logic [31:0] data;
    logic [9:0]  addr;
    logic        part;
    logic [9:0]  eaddr;
    logic [31:0] edata;
    logic [3:0]  emask;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d,
                       input logic [9:0] a);
    in_valid = v;
    conf     = c;
    in_data  = d;
    in_addr  = a;
  endtask

  task automatic chk_out(input string name, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_addr"}, {22'b0, out_addr}, {22'b0, a});
    chk({name, "_data"}, out_data, d);
    chk({name, "_mask"}, {28'b0, out_wmask}, {28'b0, m});
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'hDEADBEEF, 10'd5,     1'b0, 10'd5,     32'hDEADBEEF, 4'hF};
    vecs[1] = '{2'b00, 32'h12345678, 10'h3FF,   1'b0, 10'h3FF,   32'h12345678, 4'hF};
    vecs[2] = '{2'b11, 32'hCAFEF00D, 10'd7,     1'b0, 10'd7,     32'hCAFEF00D, 4'hF};
    vecs[3] = '{2'b01, 32'h0000ABCD, 10'd3,     1'b1, 10'd1,     32'hABCD0000, 4'hC};
    vecs[4] = '{2'b01, 32'hFFFF1234, 10'd4,     1'b1, 10'd2,     32'h00001234, 4'h3};
    vecs[5] = '{2'b10, 32'h0000005A, 10'd2,     1'b1, 10'd0,     32'h005A0000, 4'h4};
    vecs[6] = '{2'b10, 32'h000000A5, 10'h3FF,   1'b1, 10'hFF,    32'hA5000000, 4'h8};
    vecs[7] = '{2'b10, 32'hFFFFFF77, 10'd17,    1'b1, 10'd4,     32'h00007700, 4'h2};
    vecs[8] = '{2'b01, 32'h0000BEEF, 10'h3FF,   1'b1, 10'h1FF,   32'hBEEF0000, 4'hC};

    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_mask", {28'b0, out_wmask}, 32'h0);
    chk("rst_addr", {22'b0, out_addr}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", {31'b0, in_ready}, 32'd1);

    // Table: one write, optional flush, check emitted word, back to idle.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].conf, vecs[i].data, vecs[i].addr);
      tick();
      drive(1'b0, 2'b00, 32'h0, 10'h0);
      if (vecs[i].part) begin
        chk($sformatf("v%0d_not_yet", i), {31'b0, out_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      chk_out($sformatf("v%0d", i), vecs[i].eaddr, vecs[i].edata, vecs[i].emask);
      tick();
      chk($sformatf("v%0d_idle", i), {31'b0, out_valid}, 32'd0);
    end

    // Back-to-back 32-bit writes: one word per cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'hA0000000 + i, 10'd10 + 10'(i));
      @(negedge clk);
      chk($sformatf("b2b%0d_ready", i), {31'b0, in_ready}, 32'd1);
      tick();
      chk_out($sformatf("b2b%0d", i), 10'd10 + 10'(i), 32'hA0000000 + i, 4'hF);
    end
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    tick();
    chk("b2b_idle", {31'b0, out_valid}, 32'd0);

    // Four bytes into one word.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 32'h11 * (i + 1), 10'd8 + 10'(i));
      @(negedge clk);
      chk($sformatf("byte%0d_ready", i), {31'b0, in_ready}, 32'd1);
      tick();
      if (i < 3) chk($sformatf("byte%0d_pending", i), {31'b0, out_valid}, 32'd0);
    end
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    chk_out("bytes", 10'd2, 32'h44332211, 4'hF);
    tick();

    // Address change in ACCUM: partial word first, then the retried write.
    drive(1'b1, 2'b01, 32'h0000ABCD, 10'd3);
    tick();
    drive(1'b1, 2'b01, 32'h00001111, 10'd6);
    @(negedge clk);
    chk("amiss_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk_out("amiss", 10'd1, 32'hABCD0000, 4'hC);
    @(negedge clk);
    chk("retry_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    chk("retry_accum", {31'b0, out_valid}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("retry", 10'd3, 32'h00001111, 4'h3);
    tick();

    // Idle timeout: out_valid after exactly 8 idle cycles.
    drive(1'b1, 2'b10, 32'h0000005A, 10'd2);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("tmo_wait%0d", i), {31'b0, out_valid}, 32'd0);
    end
    tick();
    chk_out("tmo", 10'd0, 32'h005A0000, 4'h4);
    tick();

    // Flush on the cycle after accept.
    drive(1'b1, 2'b10, 32'h0000005A, 10'd2);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("flush", 10'd0, 32'h005A0000, 4'h4);
    tick();

    // Width change in ACCUM is a miss.
    drive(1'b1, 2'b10, 32'h00000099, 10'd0);
    tick();
    drive(1'b1, 2'b01, 32'h00004321, 10'd0);
    @(negedge clk);
    chk("cmiss_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk_out("cmiss", 10'd0, 32'h00000099, 4'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("cmiss16", 10'd0, 32'h00004321, 4'h3);
    tick();

    // Backpressure: outputs hold while out_ready=0, handoff plus reload.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0BADF00D, 10'd9);
    tick();
    drive(1'b1, 2'b00, 32'h13572468, 10'd20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ready", i), {31'b0, in_ready}, 32'd0);
      chk_out($sformatf("stall%0d", i), 10'd9, 32'h0BADF00D, 4'hF);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    chk_out("handoff", 10'd20, 32'h13572468, 4'hF);
    tick();
    chk("handoff_idle", {31'b0, out_valid}, 32'd0);

    // Reset mid-accumulation discards the partial word.
    drive(1'b1, 2'b01, 32'h00007777, 10'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_mask", {28'b0, out_wmask}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_noemit", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 2'b10, 32'h00000042, 10'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 10'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("fresh", 10'd0, 32'h00004200, 4'h2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
